// File: rtl/ghz_err_window.sv
// ghz_err_window: checks the aligned A/B/C sifted stream against the GHZ rule and reports errors per 2**WIN_LOG2-sample window.
// Optional per-basis error counts (err_z/err_x) when GHZ_ERR_SPLIT_BASIS_EN is defined.
module ghz_err_window #(
  parameter int WIN_LOG2 = 10,
  parameter int CNT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             start,
  input  logic             cont,
  input  logic             in_vld,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             c_bit,
  input  logic             basis_x,
  input  logic             exp_par,
  output logic             busy,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [CNT_W-1:0] err_cnt,
`ifdef GHZ_ERR_SPLIT_BASIS_EN
  output logic [CNT_W-1:0] err_z,
  output logic [CNT_W-1:0] err_x,
`endif
  output logic             ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [WIN_LOG2-1:0] smp_cnt;
  logic [CNT_W-1:0]    acc;
  logic [CNT_W-1:0]    err_inc;
  logic                accept, last, close, go, err;

  assign go      = ce && start && (state == IDLE);
  assign accept  = ce && in_vld && (state == RUN);
  assign last    = (smp_cnt == {WIN_LOG2{1'b1}});
  assign close   = accept && last;
  assign err_inc = CNT_W'(err);

  // X basis compares measured parity with the expected one; Z basis needs all three bits equal
  always_comb begin
    err = 1'b0;
    if (basis_x)
      err = ((a_bit ^ b_bit ^ c_bit) != exp_par);
    else
      err = !((a_bit == b_bit) && (b_bit == c_bit));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (go) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (close && !cont) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sample counting only moves on accepts; the result handshake runs regardless of ce
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt <= '0;
      acc     <= '0;
      err_cnt <= '0;
      res_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (go) begin
        smp_cnt <= '0;
        acc     <= '0;
        ovf     <= 1'b0;
      end else if (accept) begin
        smp_cnt <= smp_cnt + WIN_LOG2'(1);
        if (last) begin
          err_cnt <= acc + err_inc;
          acc     <= '0;
          if (res_vld && !res_rdy) ovf <= 1'b1;
        end else begin
          acc <= acc + err_inc;
        end
      end

      if (close)
        res_vld <= 1'b1;
      else if (res_vld && res_rdy)
        res_vld <= 1'b0;
    end
  end

`ifdef GHZ_ERR_SPLIT_BASIS_EN
  logic [CNT_W-1:0] acc_z, acc_x;
  logic [CNT_W-1:0] inc_z, inc_x;

  assign inc_z = basis_x ? '0 : err_inc;
  assign inc_x = basis_x ? err_inc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_z <= '0;
      acc_x <= '0;
      err_z <= '0;
      err_x <= '0;
    end else if (go) begin
      acc_z <= '0;
      acc_x <= '0;
    end else if (accept) begin
      if (last) begin
        err_z <= acc_z + inc_z;
        err_x <= acc_x + inc_x;
        acc_z <= '0;
        acc_x <= '0;
      end else begin
        acc_z <= acc_z + inc_z;
        acc_x <= acc_x + inc_x;
      end
    end
  end
`endif

endmodule
